// File: rtl/rtc_timer.sv
// Purpose: RTC tick synchroniser, 64-bit mtime/mtimecmp with level irq, 32-bit register port with hi shadow.
// Latency: rtc_i rise -> tick_o in SYNC_STAGES+1..+2 edges; mtime +1 the edge after tick_o; irq_o and rd_data_o one edge.
// Backpressure: none; one write and one read per cycle, both always accepted. Optional macro: RTC_TIMER_PRESCALE_EN.
module rtc_timer #(
  parameter int unsigned SYNC_STAGES = 2,
`ifdef RTC_TIMER_PRESCALE_EN
  parameter int unsigned PRESCALE    = 4,
`endif
  parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        en_i,
  input  logic        rtc_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  input  logic [1:0]  rd_sel_i,
  output logic [31:0] rd_data_o,
  output logic        tick_o,
  output logic        irq_o
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   rise;
  logic [63:0]            mtime;
  logic [63:0]            mtimecmp;
  logic [31:0]            shadow;

  // History flop tracks the synchronised level regardless of en_i, so a late enable never fakes an edge.
  assign rise = sync[SYNC_STAGES-1] & ~hist;

  // Synchroniser chain and edge-history flop.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rtc_i};
      hist <= sync[SYNC_STAGES-1];
    end
  end

`ifdef RTC_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  // Prescaler advances only on accepted rises; tick fires on its wrap.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pre_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      tick_o <= rise & en_i & (pre_cnt == PRESCALE_LAST_OK());
      if (rise && en_i) begin
        pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      end
    end
  end

  function automatic logic [PW-1:0] PRESCALE_LAST_OK();
    return PRE_LAST;
  endfunction
`else
  // Every accepted rise becomes a one-cycle tick.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      tick_o <= 1'b0;
    end else begin
      tick_o <= rise & en_i;
    end
  end
`endif

  // mtime: a software write to either half beats the increment in that cycle (no carry into the other half).
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mtime <= '0;
    end else if (wr_en_i && wr_sel_i == 2'd0) begin
      mtime[31:0] <= wr_data_i;
    end else if (wr_en_i && wr_sel_i == 2'd1) begin
      mtime[63:32] <= wr_data_i;
    end else if (tick_o) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp half writes.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mtimecmp <= CMP_RESET;
    end else if (wr_en_i && wr_sel_i == 2'd2) begin
      mtimecmp[31:0] <= wr_data_i;
    end else if (wr_en_i && wr_sel_i == 2'd3) begin
      mtimecmp[63:32] <= wr_data_i;
    end
  end

  // Level interrupt from the current register values; no sticky state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (mtime >= mtimecmp);
    end
  end

  // Reads see pre-write values; a lo read snapshots the hi half so lo-then-hi is atomic.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rd_data_o <= '0;
      shadow    <= '0;
    end else if (rd_en_i) begin
      case (rd_sel_i)
        2'd0: begin
          rd_data_o <= mtime[31:0];
          shadow    <= mtime[63:32];
        end
        2'd1:    rd_data_o <= shadow;
        2'd2:    rd_data_o <= mtimecmp[31:0];
        default: rd_data_o <= mtimecmp[63:32];
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_timer.sv
// Randomised bench for rtc_timer: reads are scored against a queue filled by the stimulus side,
// tick pulses are counted per rtc period, and a plain-arithmetic model tracks mtime/mtimecmp/shadow.
module tb_rtc_timer;

  logic        clk_i = 1'b0;
  logic        arst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic        rtc_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [1:0]  wr_sel_i = 2'd0;
  logic [31:0] wr_data_i = 32'd0;
  logic        rd_en_i = 1'b0;
  logic [1:0]  rd_sel_i = 2'd0;
  logic [31:0] rd_data_o;
  logic        tick_o;
  logic        irq_o;

  rtc_timer dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .en_i(en_i), .rtc_i(rtc_i),
    .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .tick_o(tick_o), .irq_o(irq_o)
  );

  always #3 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] d;
    logic        irq;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          tick_cnt = 0;

  // reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  int          m_pre;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_time = 64'd0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_shadow = 32'd0;
    m_pre = 0;
  endfunction

  // does the next accepted rise produce a tick?
  function automatic bit next_ticks();
`ifdef RTC_TIMER_PRESCALE_EN
    return (m_pre == 3);
`else
    return 1'b1;
`endif
  endfunction

  // account for one accepted rise; returns whether it ticks
  function automatic bit model_rise();
`ifdef RTC_TIMER_PRESCALE_EN
    m_pre = (m_pre + 1) % 4;
    return (m_pre == 0);
`else
    return 1'b1;
`endif
  endfunction

  // monitor: score reads one edge after they are issued, count tick pulses
  initial begin
    bit pend;
    rd_exp_t e;
    forever begin
      @(posedge clk_i);
      pend = rd_en_i;
      @(negedge clk_i);
      if (tick_o) tick_cnt++;
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", {32'd0, rd_data_o}, {32'd0, e.d});
          check("rd_irq", {63'd0, irq_o}, {63'd0, e.irq});
        end
      end
    end
  end

  // one register cycle: optional write and optional read in the same edge
  task automatic op(input bit w, input logic [1:0] ws, input logic [31:0] wd,
                    input bit r, input logic [1:0] rs);
    rd_exp_t e;
    @(negedge clk_i);
    wr_en_i = w; wr_sel_i = ws; wr_data_i = wd;
    rd_en_i = r; rd_sel_i = rs;
    if (r) begin
      case (rs)
        2'd0: e.d = m_time[31:0];
        2'd1: e.d = m_shadow;
        2'd2: e.d = m_cmp[31:0];
        default: e.d = m_cmp[63:32];
      endcase
      e.irq = (m_time >= m_cmp);
      exp_q.push_back(e);
      if (rs == 2'd0) m_shadow = m_time[63:32];
    end
    if (w) begin
      case (ws)
        2'd0: m_time[31:0] = wd;
        2'd1: m_time[63:32] = wd;
        2'd2: m_cmp[31:0] = wd;
        default: m_cmp[63:32] = wd;
      endcase
    end
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0;
  endtask

  // one full rtc period; mid=1 raises en_i only while rtc_i is already high
  task automatic pulse(input bit e, input bit mid);
    int t0;
    bit exp_tick;
    @(negedge clk_i);
    en_i = mid ? 1'b0 : e;
    repeat (2) @(negedge clk_i);
    t0 = tick_cnt;
    rtc_i = 1'b1;
    repeat (6) @(negedge clk_i);
    if (mid) en_i = 1'b1;
    repeat (4) @(negedge clk_i);
    rtc_i = 1'b0;
    repeat (8) @(negedge clk_i);
    exp_tick = 1'b0;
    if (e && !mid) exp_tick = model_rise();
    if (exp_tick) m_time = m_time + 64'd1;
    check(mid ? "tick_mid_enable" : "tick_count", 64'(tick_cnt - t0), {63'd0, exp_tick});
  endtask

  // write mtime lo in the very cycle tick_o is high: the write must win
  task automatic collide(input logic [31:0] wd);
    bit seen;
    while (!next_ticks()) pulse(1'b1, 1'b0);
    @(negedge clk_i);
    en_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rtc_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk_i);
      if (tick_o) seen = 1'b1;
    end
    check("collision_tick_seen", {63'd0, seen}, 64'd1);
    void'(model_rise());
    if (seen) begin
      wr_en_i = 1'b1; wr_sel_i = 2'd0; wr_data_i = wd;
      @(posedge clk_i);
      #1 wr_en_i = 1'b0;
      m_time[31:0] = wd;
    end else begin
      m_time = m_time + 64'd1;
    end
    repeat (4) @(negedge clk_i);
    rtc_i = 1'b0;
    repeat (8) @(negedge clk_i);
  endtask

  function automatic logic [31:0] pick_data();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'hFFFF_FFFE;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #5;
    check("reset_rd_data", {32'd0, rd_data_o}, 64'd0);
    check("reset_irq", {63'd0, irq_o}, 64'd0);
    check("reset_tick", {63'd0, tick_o}, 64'd0);
    #10 arst_ni = 1'b1;

    // reset values through the register port
    op(0, 0, 0, 1, 2'd2);
    op(0, 0, 0, 1, 2'd3);
    op(0, 0, 0, 1, 2'd0);
    op(0, 0, 0, 1, 2'd1);

    // plain counting
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
    op(0, 0, 0, 1, 2'd0);
    op(0, 0, 0, 1, 2'd1);

    // enable gating: dropped edges and a late enable during rtc high
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
    op(0, 0, 0, 1, 2'd0);

    // compare and interrupt
    op(1, 2'd0, 32'd0, 0, 0);
    op(1, 2'd1, 32'd0, 0, 0);
    op(1, 2'd3, 32'd0, 0, 0);
    op(1, 2'd2, 32'd5, 1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0);
      op(0, 0, 0, 1, 2'd0);
    end
    op(1, 2'd3, 32'd1, 1, 2'd3);
    op(0, 0, 0, 1, 2'd3);

    // carry and atomic hi read via the shadow
    op(1, 2'd0, 32'hFFFF_FFFF, 0, 0);
    op(1, 2'd1, 32'd0, 0, 0);
    op(0, 0, 0, 1, 2'd0);
    while (!next_ticks()) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    op(0, 0, 0, 1, 2'd1);
    op(0, 0, 0, 1, 2'd0);
    op(0, 0, 0, 1, 2'd1);

    // write/increment collision
    collide(32'h100);
    op(0, 0, 0, 1, 2'd0);
    op(0, 0, 0, 1, 2'd1);

    // randomised mix
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1: pulse(1'b1, 1'b0);
        2:    pulse(($urandom_range(0, 3) != 0), 1'b0);
        3:    pulse(1'b1, 1'b1);
        default: op($urandom_range(0, 1), 2'($urandom_range(0, 3)), pick_data(),
                    $urandom_range(0, 1), 2'($urandom_range(0, 3)));
      endcase
    end
    op(0, 0, 0, 1, 2'd0);
    op(0, 0, 0, 1, 2'd1);

    // reset in the middle of operation with irq asserted
    op(1, 2'd0, 32'd30, 0, 0);
    op(1, 2'd1, 32'd0, 0, 0);
    op(1, 2'd3, 32'd0, 0, 0);
    op(1, 2'd2, 32'd5, 0, 0);
    op(0, 0, 0, 1, 2'd0);
    repeat (2) @(negedge clk_i);
    check("pre_reset_irq", {63'd0, irq_o}, 64'd1);
    #1 arst_ni = 1'b0;
    #1;
    check("midreset_rd_data", {32'd0, rd_data_o}, 64'd0);
    check("midreset_irq", {63'd0, irq_o}, 64'd0);
    check("midreset_tick", {63'd0, tick_o}, 64'd0);
    #14 arst_ni = 1'b1;
    model_reset();
    op(0, 0, 0, 1, 2'd0);
    op(0, 0, 0, 1, 2'd2);
    op(0, 0, 0, 1, 2'd3);
    for (int i = 0; i < 8; i++) pulse(1'b1, 1'b0);
    op(0, 0, 0, 1, 2'd0);

    repeat (3) @(negedge clk_i);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
